// File: rtl/param_deserializer.sv
// Serial-to-parallel frame assembler: collects FEATURES*NUM_OUTS elements into a capture buffer,
// then hands the whole frame to a registered output slot with a valid/ready handshake.
module param_deserializer #(
    parameter int unsigned ELEMENT_BITS = 8,
    parameter int unsigned FEATURES     = 4,
    parameter int unsigned NUM_OUTS     = 2
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     start,
    input  logic                                     in_valid,
    input  logic [ELEMENT_BITS-1:0]                  in_data,
    output logic                                     in_ready,
    output logic [NUM_OUTS*FEATURES*ELEMENT_BITS-1:0] out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     done,
    output logic                                     busy
);

    localparam int unsigned TOTAL  = FEATURES * NUM_OUTS;
    localparam int unsigned FrameW = TOTAL * ELEMENT_BITS;
    localparam int unsigned CntW   = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StLoad} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ELEMENT_BITS-1:0] cap_q [TOTAL];
    logic [ELEMENT_BITS-1:0] cap_d [TOTAL];
    logic [FrameW-1:0]       cap_flat;
    logic [FrameW-1:0]       out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    done_q, done_d;

    // Element k sits at bit k*ELEMENT_BITS, which is vector k/FEATURES, slot k%FEATURES.
    always_comb begin
        cap_flat = '0;
        for (int unsigned k = 0; k < TOTAL; k++) begin
            cap_flat[k*ELEMENT_BITS +: ELEMENT_BITS] = cap_q[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCollect;
                    cnt_d   = '0;
                end
            end
            StCollect: begin
                if (in_valid) begin
                    for (int unsigned k = 0; k < TOTAL; k++) begin
                        if (cnt_q == CntW'(k)) begin
                            cap_d[k] = in_data;
                        end
                    end
                    if (cnt_q == CntW'(TOTAL - 1)) begin
                        cnt_d   = '0;
                        state_d = StLoad;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StLoad: begin
                // A load may coincide with the drain of the previous frame.
                if (!out_valid_q || out_ready) begin
                    out_data_d  = cap_flat;
                    out_valid_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Capture buffer is always overwritten before use, so it carries no reset.
    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

    assign in_ready  = (state_q == StCollect);
    assign busy      = (state_q != StIdle);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_param_deserializer.sv
// Scoreboard bench for param_deserializer: driver pushes expected frames, a negedge monitor
// pops and compares on every done pulse and checks the output handshake each cycle.
module tb_param_deserializer;

    localparam int EB    = 8;
    localparam int F     = 4;
    localparam int NO    = 2;
    localparam int TOTAL = F * NO;
    localparam int W     = TOTAL * EB;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         in_valid;
    logic [EB-1:0] in_data;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         done;
    logic         busy;

    // Second instance: NUM_OUTS=1, FEATURES=3, ELEMENT_BITS=16.
    logic         start2;
    logic         in_valid2;
    logic [15:0]  in_data2;
    logic         in_ready2;
    logic [47:0]  out_data2;
    logic         out_valid2;
    logic         out_ready2;
    logic         done2;
    logic         busy2;

    int n_vec = 0;
    int n_bad = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready
    logic [W-1:0] sb_q[$];

    always #5 clk = ~clk;

    param_deserializer #(.ELEMENT_BITS(EB), .FEATURES(F), .NUM_OUTS(NO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .busy      (busy)
    );

    param_deserializer #(.ELEMENT_BITS(16), .FEATURES(3), .NUM_OUTS(1)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start2),
        .in_valid  (in_valid2),
        .in_data   (in_data2),
        .in_ready  (in_ready2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .done      (done2),
        .busy      (busy2)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame built from the placement rule: element k -> vector k/F, slot k%F.
    function automatic logic [W-1:0] model_frame(input logic [EB-1:0] e [TOTAL]);
        logic [W-1:0] f;
        f = '0;
        for (int k = 0; k < TOTAL; k++) begin
            f[(k / F) * F * EB + (k % F) * EB +: EB] = e[k];
        end
        return f;
    endfunction

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 500) begin
            tick();
            c++;
        end
        if (busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, c);
        end
    endtask

    task automatic wait_drained();
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < 500) begin
            tick();
            c++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d frames pending, required 0", sb_q.size());
        end
    endtask

    task automatic send_frame(input logic [EB-1:0] e [TOTAL], input bit gaps, input bit noise,
                              input bit push);
        wait_idle();
        if (push) sb_q.push_back(model_frame(e));
        if (noise) begin
            in_valid = 1'b1;
            in_data  = EB'($urandom);
            tick();
        end
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < TOTAL; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = EB'($urandom);
                    start    = noise ? 1'($urandom) : 1'b0;
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = e[k];
            start    = noise ? 1'($urandom) : 1'b0;
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare on done, check valid/data handshake against the previous cycle.
    initial begin
        logic         prev_ok, prev_v, prev_r, prev_d;
        logic [W-1:0] prev_data, exp_f;
        prev_ok = 1'b0;
        prev_v  = 1'b0;
        prev_r  = 1'b0;
        prev_d  = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                prev_ok = 1'b0;
            end else begin
                if (done === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_done: got done=1 required no frame pending");
                    end else begin
                        exp_f = sb_q.pop_front();
                        check("frame_data", out_data, exp_f);
                    end
                end
                if (prev_ok) begin
                    check("out_valid_seq", out_valid, done ? 1'b1 : (prev_v & ~prev_r));
                    if (prev_d) check("done_one_cycle", done, 1'b0);
                    if (prev_v && !prev_r) check("out_data_stable", out_data, prev_data);
                end
                prev_ok = 1'b1;
            end
            prev_v    = out_valid;
            prev_r    = out_ready;
            prev_d    = done;
            prev_data = out_data;
        end
    end

    initial begin
        logic [EB-1:0] fa [TOTAL];
        logic [EB-1:0] fb [TOTAL];
        logic [EB-1:0] fr [TOTAL];
        logic [W-1:0]  frame_a;
        int c;

        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        start2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        for (int k = 0; k < TOTAL; k++) begin
            fa[k] = EB'(k + 1);
            fb[k] = EB'(8'h11 + k);
        end
        frame_a = 64'h0807060504030201;
        repeat (3) tick();
        check("rst_out_data", out_data, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        tick();

        // Basic frame, always ready.
        ready_mode = 0;
        send_frame(fa, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(frame_a);
        wait_idle();
        wait_drained();

        // Gaps between accepts, noise on start and on in_valid in idle.
        send_frame(fa, 1'b1, 1'b1, 1'b0);
        sb_q.push_back(frame_a);
        wait_idle();
        wait_drained();

        // Stall in LOAD with frame A held, then same-edge drain and load of frame B.
        ready_mode = 2;
        send_frame(fa, 1'b0, 1'b0, 1'b1);
        wait_idle();
        send_frame(fb, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(64'h1817161514131211);
        repeat (4) begin
            tick();
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_busy", busy, 1'b1);
            check("stall_data", out_data, frame_a);
        end
        ready_mode = 0;
        wait_idle();
        wait_drained();

        // Reset after three accepted elements.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = fb[k];
            tick();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        check("midrst_out_data", out_data, '0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_busy", busy, 1'b0);
        reset_n = 1'b1;
        tick();
        check("postrst_done", done, 1'b0);
        send_frame(fa, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(frame_a);
        wait_idle();
        wait_drained();

        // Randomized frames with random back-pressure.
        ready_mode = 1;
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < TOTAL; k++) fr[k] = EB'($urandom);
            send_frame(fr, 1'($urandom), 1'($urandom), 1'b1);
        end
        ready_mode = 0;
        wait_idle();
        wait_drained();

        // Second configuration: 3 x 16-bit elements in a single vector.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid2 = 1'b1;
            in_data2  = 16'(k + 1);
            tick();
        end
        in_valid2 = 1'b0;
        c = 0;
        while (done2 !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        check("cfg2_done", done2, 1'b1);
        check("cfg2_valid", out_valid2, 1'b1);
        check("cfg2_data", out_data2, 48'h000300020001);
        tick();
        check("cfg2_done_pulse", done2, 1'b0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/param_deserializer.md
PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 Parameter ELEMENT_BITS, default 8, width of one serial element.
REQ-002 Parameter FEATURES, default 4, elements per output vector; SHALL be >= 1.
REQ-003 Parameter NUM_OUTS, default 2, output vectors per frame; SHALL be >= 1; TOTAL = FEATURES*NUM_OUTS.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  frame-start request, sampled in IDLE only.
REQ-007 in_valid  input  1  serial element present on in_data.
REQ-008 in_data  input  ELEMENT_BITS  serial element.
REQ-009 in_ready  output  1  block accepts element this cycle.
REQ-010 out_data  output  NUM_OUTS*FEATURES*ELEMENT_BITS  frame; vector j at bits [j*FEATURES*ELEMENT_BITS +: FEATURES*ELEMENT_BITS].
REQ-011 out_valid  output  1  out_data holds a complete, unconsumed frame.
REQ-012 out_ready  input  1  consumer takes out_data when out_valid is high.
REQ-013 done  output  1  one-cycle pulse when a frame is loaded into out_data.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, COLLECT, LOAD; all outputs registered except in_ready and busy, which decode state.
REQ-016 IDLE: in_ready=0; in_valid ignored; start=1 -> COLLECT with element counter cleared to 0.
REQ-017 COLLECT: in_ready=1; accept = in_valid & in_ready; each accept writes in_data into capture buffer slot k = counter, then counter increments.
REQ-018 Element k SHALL land in vector k/FEATURES, slot k%FEATURES, slot 0 in the least-significant ELEMENT_BITS of the vector.
REQ-019 Cycles with in_valid=0 SHALL NOT advance the counter or alter the buffer.
REQ-020 Accept of element TOTAL-1 -> LOAD; counter wraps to 0.
REQ-021 LOAD: in_ready=0; output slot free when out_valid=0 or out_ready=1; if free, capture buffer copies to out_data, out_valid=1, done=1 at that edge, state -> IDLE; else remain in LOAD.
REQ-022 Latency: last element accepted at edge E, with output free, gives out_valid and done high from edge E+1.
REQ-023 out_valid SHALL clear at an edge where out_valid & out_ready and no load occurs.
REQ-024 Load and drain on the same edge: out_valid stays 1, out_data replaced by the new frame, done pulses.
REQ-025 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 start in COLLECT or LOAD SHALL be ignored with no effect on counter or buffer.
REQ-027 done SHALL be high for exactly one cycle per loaded frame.
REQ-028 The capture buffer SHALL permit collection of frame N+1 while frame N waits in out_data.

Reset
REQ-029 reset_n=0 at a rising edge -> state IDLE, counter 0, out_data 0, out_valid 0, done 0; in_ready 0 and busy 0 follow.
REQ-030 Reset mid-frame or in LOAD SHALL discard partial and pending frames; no done pulse results.
REQ-031 Capture buffer contents need not be reset.

Verification (defaults unless stated)
REQ-032 Reset, start, in_valid=1 with 01..08 on consecutive cycles, out_ready=1 -> vector0=0x04030201, vector1=0x08070605, one done pulse, out_valid high for exactly one cycle.
REQ-033 Same data with in_valid low on alternate cycles -> identical out_data; counter advances only on accepts.
REQ-034 out_ready=0 after frame 1, start frame 2 (11..18) -> LOAD stalls with in_ready=0, out_data still frame 1; raise out_ready -> same-edge drain+load, out_valid stays 1, out_data = 0x14131211 / 0x18171615.
REQ-035 Reset after 3 accepted elements -> outputs zero, no done; following full frame 01..08 correct.
REQ-036 start pulsed mid-COLLECT and in_valid driven in IDLE -> no effect; frame contents unchanged.
REQ-037 NUM_OUTS=1, FEATURES=3, ELEMENT_BITS=16, elements 0x0001..0x0003 -> out_data=0x000300020001.
